// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Round-robin arbiter sequencing cpu/dma accesses to a
//               fixed-latency single-port data RAM, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_wstrb,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [3:0]        dma_wstrb,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] C_LAT_LOAD = 3'(RD_LATENCY - 1);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_cnt;
  logic                r_owner;
  logic                r_last_owner;
  logic                r_ram_en;
  logic [3:0]          r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [31:0]         r_ram_wdata;
  logic [31:0]         r_cpu_rdata;
  logic [31:0]         r_dma_rdata;
  logic                w_cpu_win;
  logic                w_dma_win;
  logic                w_cpu_gnt;
  logic                w_dma_gnt;
  logic                w_grant;

  // cpu wins unless dma is also requesting and cpu was served last
  assign w_cpu_win = cpu_req & (~dma_req | r_last_owner);
  assign w_dma_win = dma_req & ~w_cpu_win;

  always_comb begin
    w_next    = r_state;
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && (cpu_req || dma_req)) begin
          w_cpu_gnt = w_cpu_win;
          w_dma_gnt = w_dma_win;
          w_next    = ACCESS;
        end
      end
      ACCESS: w_next = WAIT;
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_grant = w_cpu_gnt | w_dma_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The ram_* registers double as the payload latch for the granted master
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= 3'd0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 4'b0000;
      r_ram_addr   <= '0;
      r_ram_wdata  <= 32'd0;
      r_cpu_rdata  <= 32'd0;
      r_dma_rdata  <= 32'd0;
    end else begin
      r_ram_en <= w_grant;
      r_ram_we <= 4'b0000;
      if (w_grant) begin
        r_owner <= w_dma_gnt;
        if (w_dma_gnt) begin
          r_ram_addr  <= dma_addr;
          r_ram_wdata <= dma_wdata;
          r_ram_we    <= dma_we ? dma_wstrb : 4'b0000;
        end else begin
          r_ram_addr  <= cpu_addr;
          r_ram_wdata <= cpu_wdata;
          r_ram_we    <= cpu_we ? cpu_wstrb : 4'b0000;
        end
      end

      if (r_state == ACCESS) begin
        r_cnt <= C_LAT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end

      if ((r_state == WAIT) && (r_cnt == 3'd0)) begin
        if (r_owner) begin
          r_dma_rdata <= ram_rdata;
        end else begin
          r_cpu_rdata <= ram_rdata;
        end
      end

      if (r_state == RESP) begin
        r_last_owner <= r_owner;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_rvalid = (r_state == RESP) & ~r_owner;
  assign dma_rvalid = (r_state == RESP) & r_owner;
  assign cpu_rdata  = r_cpu_rdata;
  assign dma_rdata  = r_dma_rdata;
  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// Scoreboard bench for dram_arbiter: two instances (RD_LATENCY 1 and 3),
// behavioural RAM models, directed transactions with hand-computed results.
module tb_dram_arbiter;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel3 = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [3:0]  cpu_wstrb = 4'd0, dma_wstrb = 4'd0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0, dma_addr = 32'd0, dma_wdata = 32'd0;

  logic        c1_gnt, c1_rv, d1_gnt, d1_rv, r1_en;
  logic [31:0] c1_rd, d1_rd, r1_addr, r1_wdata, r1_rdata;
  logic [3:0]  r1_we;
  logic        c3_gnt, c3_rv, d3_gnt, d3_rv, r3_en;
  logic [31:0] c3_rd, d3_rd, r3_addr, r3_wdata, r3_rdata;
  logic [3:0]  r3_we;

  dram_arbiter #(.ADDR_W(32), .RD_LATENCY(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req & ~sel3), .cpu_we(cpu_we), .cpu_wstrb(cpu_wstrb), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(c1_gnt), .cpu_rvalid(c1_rv), .cpu_rdata(c1_rd),
    .dma_req(dma_req & ~sel3), .dma_we(dma_we), .dma_wstrb(dma_wstrb), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(d1_gnt), .dma_rvalid(d1_rv), .dma_rdata(d1_rd),
    .ram_en(r1_en), .ram_we(r1_we), .ram_addr(r1_addr), .ram_wdata(r1_wdata), .ram_rdata(r1_rdata)
  );

  dram_arbiter #(.ADDR_W(32), .RD_LATENCY(LAT3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req & sel3), .cpu_we(cpu_we), .cpu_wstrb(cpu_wstrb), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(c3_gnt), .cpu_rvalid(c3_rv), .cpu_rdata(c3_rd),
    .dma_req(dma_req & sel3), .dma_we(dma_we), .dma_wstrb(dma_wstrb), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(d3_gnt), .dma_rvalid(d3_rv), .dma_rdata(d3_rd),
    .ram_en(r3_en), .ram_we(r3_we), .ram_addr(r3_addr), .ram_wdata(r3_wdata), .ram_rdata(r3_rdata)
  );

  // RAM models: preload on first edge, byte-strobed writes, pipelined reads
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] rd1_q = 32'd0;
  logic [31:0] p3 [0:2];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= 32'd0;
        mem3[i] <= 32'd0;
      end
      mem1[4]  <= 32'hDEADBEEF;
      mem1[8]  <= 32'hAAAABBBB;
      mem1[17] <= 32'h11112222;
      mem3[16] <= 32'hA5A5A5A5;
      p3[0] <= 32'd0; p3[1] <= 32'd0; p3[2] <= 32'd0;
      init_done <= 1'b1;
    end else begin
      if (r1_en) begin
        rd1_q <= mem1[r1_addr[7:2]];
        for (int b = 0; b < 4; b++)
          if (r1_we[b]) mem1[r1_addr[7:2]][b*8 +: 8] <= r1_wdata[b*8 +: 8];
      end
      p3[0] <= r3_en ? mem3[r3_addr[7:2]] : 32'd0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
      if (r3_en)
        for (int b = 0; b < 4; b++)
          if (r3_we[b]) mem3[r3_addr[7:2]][b*8 +: 8] <= r3_wdata[b*8 +: 8];
    end
  end
  assign r1_rdata = rd1_q;
  assign r3_rdata = p3[2];

  logic        m_en;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata;
  assign m_en    = sel3 ? r3_en    : r1_en;
  assign m_we    = sel3 ? r3_we    : r1_we;
  assign m_addr  = sel3 ? r3_addr  : r1_addr;
  assign m_wdata = sel3 ? r3_wdata : r1_wdata;

  typedef struct {
    int          dut;
    bit          own;
    logic [31:0] data;
    bit          chkd;
    int          due;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic crv, input logic drv,
                     input logic [31:0] crd, input logic [31:0] drd);
    exp_t e;
    if (crv || drv) begin
      chk("rvalid_exclusive", 32'(crv & drv), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: dut%0d cpu_rvalid=%b dma_rvalid=%b cycle=%0d, required none",
                 d, crv, drv, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_dut", 32'(d), 32'(e.dut));
        chk("resp_owner", 32'(drv), 32'(e.own));
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        if (e.chkd) chk("resp_rdata", e.own ? drd : crd, e.data);
      end
    end
  endtask

  always @(posedge clk) begin
    #3;
    if (c1_gnt || d1_gnt) chk("gnt_exclusive_1", 32'(c1_gnt & d1_gnt), 32'd0);
    if (c3_gnt || d3_gnt) chk("gnt_exclusive_3", 32'(c3_gnt & d3_gnt), 32'd0);
    mon(0, c1_rv, d1_rv, c1_rd, d1_rd);
    mon(1, c3_rv, d3_rv, c3_rd, d3_rd);
  end

  task automatic set_req(input bit m, input bit r, input bit we, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] w);
    if (m) begin
      dma_req = r; dma_we = we; dma_wstrb = s; dma_addr = a; dma_wdata = w;
    end else begin
      cpu_req = r; cpu_we = we; cpu_wstrb = s; cpu_addr = a; cpu_wdata = w;
    end
  endtask

  task automatic wait_gnt(input bit m, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m ? (sel3 ? d3_gnt : d1_gnt) : (sel3 ? c3_gnt : c1_gnt)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: master=%0d got no grant within 20 cycles", m);
    end
  endtask

  task automatic push(input bit m, input int t, input logic [31:0] d, input bit c);
    exp_t e;
    e.dut  = sel3 ? 1 : 0;
    e.own  = m;
    e.data = d;
    e.chkd = c;
    e.due  = t + (sel3 ? LAT3 : LAT1) + 2;
    if (t >= 0) sb.push_back(e);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic xact(input bit m, input bit we, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] w, input logic [31:0] exp, input bit c);
    int t;
    @(posedge clk); #1;
    set_req(m, 1'b1, we, s, a, w);
    wait_gnt(m, t);
    push(m, t, exp, c);
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    if (t >= 0) begin
      @(negedge clk);
      chk("ram_en_T1", 32'(m_en), 32'd1);
      chk("ram_we_T1", 32'(m_we), 32'(we ? s : 4'b0000));
      chk("ram_addr_T1", m_addr, a);
      if (we) chk("ram_wdata_T1", m_wdata, w);
      @(negedge clk);
      chk("ram_en_T2", 32'(m_en), 32'd0);
    end
    wait_empty();
  endtask

  task automatic reset_vals();
    chk("rst_cpu_gnt", 32'(c1_gnt), 32'd0);
    chk("rst_dma_gnt", 32'(d1_gnt), 32'd0);
    chk("rst_cpu_rvalid", 32'(c1_rv), 32'd0);
    chk("rst_dma_rvalid", 32'(d1_rv), 32'd0);
    chk("rst_ram_en", 32'(r1_en), 32'd0);
    chk("rst_ram_we", 32'(r1_we), 32'd0);
    chk("rst_ram_addr", r1_addr, 32'd0);
    chk("rst_ram_wdata", r1_wdata, 32'd0);
    chk("rst_cpu_rdata", c1_rd, 32'd0);
    chk("rst_dma_rdata", d1_rd, 32'd0);
    chk("rst_ram_en_3", 32'(r3_en), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2, n;
    int gt [0:3];
    bit go [0:3];

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    reset_vals();

    // single cpu load, store with partial strobes, readback
    xact(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    chk("dma_rdata_untouched", d1_rd, 32'd0);
    xact(1'b0, 1'b1, 4'b0011, 32'h20, 32'h12345678, 32'h0, 1'b0);
    xact(1'b0, 1'b0, 4'b0000, 32'h20, 32'h0, 32'hAAAA5678, 1'b1);
    // dma store with no strobes: ram_we stays 0, RAM untouched, still responds
    xact(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0);
    xact(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    chk("cpu_rdata_hold", c1_rd, 32'hDEADBEEF);

    // dma request arriving while cpu is in WAIT
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 4'd0, 32'h44, 32'h0);
    wait_gnt(1'b0, t);
    push(1'b0, t, 32'h11112222, 1'b1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 1'b0, 4'd0, 32'h10, 32'h0);
    @(negedge clk);
    chk("dma_gnt_in_wait", 32'(d1_gnt), 32'd0);
    @(negedge clk);
    chk("dma_gnt_in_resp", 32'(d1_gnt), 32'd0);
    @(negedge clk);
    chk("dma_gnt_after_resp", 32'(d1_gnt), 32'd1);
    chk("dma_gnt_cycle", 32'(cyc), 32'(t + 4));
    if (d1_gnt) push(1'b1, cyc, 32'hDEADBEEF, 1'b1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    wait_empty();

    // both masters requesting continuously from reset
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 4'd0, 32'h10, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 4'd0, 32'h44, 32'h0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (c1_gnt || d1_gnt) begin
        gt[n] = cyc;
        go[n] = d1_gnt;
        push(d1_gnt, cyc, d1_gnt ? 32'h11112222 : 32'hDEADBEEF, 1'b1);
        n++;
      end
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    chk("rr_grant_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) begin
      chk("rr_owner", 32'(go[k]), 32'(k % 2));
      if (k > 0) chk("rr_spacing", 32'(gt[k] - gt[k-1]), 32'd4);
    end
    wait_empty();

    // reset during WAIT abandons the load; next request granted right after
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 4'd0, 32'h10, 32'h0);
    wait_gnt(1'b0, t);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 4'd0, 32'h20, 32'h0);
    wait_gnt(1'b0, t2);
    chk("gnt_after_reset", 32'(t2), 32'(t + 3));
    push(1'b0, t2, 32'hAAAA5678, 1'b1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    wait_empty();

    // RD_LATENCY=3 instance: dma load
    @(posedge clk); #1;
    sel3 = 1'b1;
    xact(1'b1, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b1);
    repeat (2) @(negedge clk);
    chk("dma3_rdata_hold", d3_rd, 32'hA5A5A5A5);
    chk("cpu3_rdata_idle", c3_rd, 32'd0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Arbitrates the single-port data RAM between the pipeline's load/store port (cpu) and a secondary master (dma/debug loader).
- Sequences each access through a fixed-latency RAM, captures read data and returns a response pulse.
- The memory stage uses cpu_rvalid as its ready_go, so pipeline stalls follow arbitration and RAM latency.
- One transaction in flight at a time.

Parameters:
- ADDR_W, 32, byte address width for both masters and the RAM.
- RD_LATENCY, 1, cycles from ram_en high to ram_rdata valid; legal range 1..7.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  cpu access request; held with payload until cpu_gnt
- cpu_we  in  1  1=store, 0=load
- cpu_wstrb  in  4  byte write strobes
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data
- cpu_gnt  out  1  request accepted this cycle; payload sampled
- cpu_rvalid  out  1  one-cycle response pulse (loads and stores)
- cpu_rdata  out  32  load data, valid with cpu_rvalid
- dma_req, dma_we, dma_wstrb, dma_addr, dma_wdata  in  1/1/4/ADDR_W/32  same meaning as the cpu inputs, dma master
- dma_gnt, dma_rvalid  out  1  same as cpu
- dma_rdata  out  32  same as cpu
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables; 0 for reads
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. A 3-bit latency counter and a 1-bit owner register (0=cpu, 1=dma) support the FSM.
- IDLE: if any request is present, pick the winner, assert its gnt combinationally for one cycle, latch the payload and owner, and go to ACCESS. With no request, stay in IDLE.
- Priority is round-robin on last_owner. After reset last_owner=dma, so cpu wins first. On simultaneous requests the master that was not last granted wins. A lone requester always wins.
- ACCESS (1 cycle):
  - ram_en=1.
  - ram_addr and ram_wdata come from the latch.
  - ram_we = wstrb if we else 4'b0000.
  - Load counter to RD_LATENCY-1, go to WAIT.
- WAIT: ram_en=0. When counter==0, capture ram_rdata into the owner's rdata register and go to RESP. Otherwise decrement the counter.
- RESP (1 cycle): owner's rvalid=1, rdata holds the captured value, update last_owner, go to IDLE.
- Stores also capture ram_rdata, and that value is don't-care for the verifier. we=1 with wstrb=0 runs the full sequence with ram_we=0 and still responds.
- Latency from gnt cycle T:
  - ram_en in cycle T+1.
  - RESP/rvalid in cycle T+1+RD_LATENCY+1 (T+3 at default).
  - Next gnt no earlier than the cycle after RESP.
- rdata registers hold their value until that master's next response.
- gnt is never asserted outside IDLE; requests arriving in other states wait.
- Both gnt signals are never high in the same cycle, and neither are both rvalid signals.
- Drop of req before gnt is permitted; the master is simply not served.
- Reset values:
  - state=IDLE, last_owner=dma.
  - All gnt/rvalid=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_rdata=0, dma_rdata=0.
- Reset mid-transaction abandons it: no rvalid is issued, and a RAM write already strobed is not undone.
- ram_* outputs are registered. In states other than ACCESS, ram_en=0 and ram_we=0, while ram_addr and ram_wdata hold their last values.

Test Plan:
- Reset then single cpu load addr 0x10, RAM model returns 0xDEADBEEF: cpu_gnt at T, ram_en=1/ram_we=0 at T+1, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF at T+3, dma_* outputs stay 0.
- cpu store addr 0x20, wdata 0x12345678, wstrb 4'b0011: ram_we=4'b0011, ram_wdata=0x12345678 at T+1, cpu_rvalid pulse at T+3, and a subsequent load of 0x20 returns 0x????5678 from the model.
- cpu_req and dma_req both held high continuously from reset: grant order is cpu, dma, cpu, dma, with gnt spacing of 4 cycles and no overlapping rvalid.
- RD_LATENCY=3, dma load addr 0x40, model data 0xA5A5A5A5: dma_rvalid at T+5 with dma_rdata=0xA5A5A5A5, and ram_en high exactly one cycle.
- rst_n low for one cycle at T+2 during a cpu load: no cpu_rvalid is ever issued, state returns to IDLE, and a new request is granted in the first cycle after reset release.
- dma_req asserted while a cpu transaction is in WAIT: dma_gnt stays 0 until the cycle after cpu RESP, then asserts.
